// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit bridging core requests to a fixed-latency memory map
// Four-state FSM: IDLE accepts, ACCESS drives strobes, WAIT counts read latency, DONE responds.
module mem_access_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_write_enable,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;
   localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic        bad_req;
   logic [31:0] byte_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [3:0]  st_strb;
   logic [31:0] st_data;

   always_comb begin
      bad_req = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   end

   always_comb begin
      byte_shift = mem_read_data >> {addr_q[1:0], 3'b000};
      ld_byte    = byte_shift[7:0];
      ld_half    = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (size_q)
         2'b00:   ld_data = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{~unsigned_q & ld_half[15]}}, ld_half};
         default: ld_data = mem_read_data;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00: begin
            st_strb = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            st_strb = addr_q[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_q[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      error_d    = error_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               rdata_d    = 32'd0;
               error_d    = bad_req;
               // Faulty requests skip the memory entirely and respond next cycle.
               state_d    = bad_req ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (write_q) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = WAIT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) begin
               rdata_d = ld_data;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            rdata_d = 32'd0;
            error_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         cnt_q      <= 3'd0;
         rdata_q    <= 32'd0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      req_ready        = (state_q == S_IDLE);
      rsp_valid        = (state_q == S_DONE);
      rsp_rdata        = rsp_valid ? rdata_q : 32'd0;
      rsp_error        = rsp_valid & error_q;
      mem_address      = (state_q == S_ACCESS || state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : 32'd0;
      mem_write_enable = (state_q == S_ACCESS && write_q) ? st_strb : 4'b0000;
      mem_write_data   = (state_q == S_ACCESS && write_q) ? st_data : 32'd0;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (latency 1 and 3)
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, sel3;
   logic        req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        rdy1, rv1, er1, rdy3, rv3, er3;
   logic [31:0] rd1, ma1, mwd1, mrd1, rd3, ma3, mwd3, mrd3;
   logic [3:0]  mwe1, mwe3;
   logic [31:0] p3_0, p3_1;

   logic        obs_rdy, obs_rv, obs_er;
   logic [31:0] obs_rd, obs_ma, obs_mwd;
   logic [3:0]  obs_mwe;

   logic [31:0] mem [16];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.READ_LATENCY(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid & ~sel3), .req_ready(rdy1),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
      .rsp_error(er1), .mem_address(ma1), .mem_write_data(mwd1),
      .mem_write_enable(mwe1), .mem_read_data(mrd1));

   mem_access_unit #(.READ_LATENCY(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid & sel3), .req_ready(rdy3),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3),
      .rsp_error(er3), .mem_address(ma3), .mem_write_data(mwd3),
      .mem_write_enable(mwe3), .mem_read_data(mrd3));

   // Memory with registered read pipelines matching each instance's latency.
   always @(posedge clk) begin
      mrd1 <= mem[ma1[5:2]];
      p3_0 <= mem[ma3[5:2]];
      p3_1 <= p3_0;
      mrd3 <= p3_1;
   end

   always_comb begin
      obs_rdy = sel3 ? rdy3 : rdy1;
      obs_rv  = sel3 ? rv3  : rv1;
      obs_er  = sel3 ? er3  : er1;
      obs_rd  = sel3 ? rd3  : rd1;
      obs_ma  = sel3 ? ma3  : ma1;
      obs_mwd = sel3 ? mwd3 : mwd1;
      obs_mwe = sel3 ? mwe3 : mwe1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_er, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ma);
      int lat = 0;
      logic [31:0] rd = 32'd0, ma_c1 = 32'd0, wd_or = 32'd0;
      logic [3:0] we_or = 4'd0;
      logic er = 1'b0, leak = 1'b0;
      @(negedge clk);
      check_eq({tag, "_ready"}, 32'(obs_rdy), 32'd1);
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (c == 1) ma_c1 = obs_ma;
         we_or |= obs_mwe;
         wd_or |= obs_mwd;
         if (obs_rv) begin
            lat = c; rd = obs_rd; er = obs_er;
         end else if (obs_rd != 32'd0 || obs_er) begin
            leak = 1'b1;
         end
      end
      check_eq({tag, "_latency"}, lat, exp_lat);
      check_eq({tag, "_rdata"}, rd, exp_rd);
      check_eq({tag, "_error"}, 32'(er), 32'(exp_er));
      check_eq({tag, "_strobes"}, 32'(we_or), 32'(exp_we));
      check_eq({tag, "_wdata"}, wd_or, exp_wd);
      check_eq({tag, "_address"}, ma_c1, exp_ma);
      check_eq({tag, "_idle_rsp_zero"}, 32'(leak), 32'd0);
   endtask

   initial begin
      int rv_cnt;
      for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      mem[0] = 32'h80F17F01;
      reset_n = 1'b0; req_valid = 1'b0; sel3 = 1'b0;
      req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h44; req_wdata = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(rdy1), 32'd1);
      check_eq("rst_rsp_valid", 32'(rv1), 32'd0);
      check_eq("rst_rdata", rd1, 32'd0);
      check_eq("rst_error", 32'(er1), 32'd0);
      check_eq("rst_mem_address", ma1, 32'd0);
      check_eq("rst_mem_wdata", mwd1, 32'd0);
      check_eq("rst_mem_we", 32'(mwe1), 32'd0);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("idle_ready", 32'(rdy1), 32'd1);
         check_eq("idle_mem_address", ma1, 32'd0);
         check_eq("idle_mem_wdata", mwd1, 32'd0);
         check_eq("idle_mem_we", 32'(mwe1), 32'd0);
      end

      run_req("st_word",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 0, 0, 4'hF, 32'hDEADBEEF, 32'h10);
      run_req("st_byte13", 1, 2'b00, 0, 32'h13, 32'h123456A5, 2, 0, 0, 4'h8, 32'hA5A5A5A5, 32'h10);
      run_req("st_byte11", 1, 2'b00, 0, 32'h11, 32'h0000005A, 2, 0, 0, 4'h2, 32'h5A5A5A5A, 32'h10);
      run_req("st_half22", 1, 2'b01, 0, 32'h22, 32'hABCD1234, 2, 0, 0, 4'hC, 32'h12341234, 32'h20);
      run_req("st_half20", 1, 2'b01, 0, 32'h20, 32'h0000BEEF, 2, 0, 0, 4'h3, 32'hBEEFBEEF, 32'h20);
      run_req("ld_sb3",    0, 2'b00, 0, 32'h3,  32'hFFFFFFFF, 3, 32'hFFFFFF80, 0, 4'h0, 0, 32'h0);
      run_req("ld_uh2",    0, 2'b01, 1, 32'h2,  32'h0, 3, 32'h000080F1, 0, 4'h0, 0, 32'h0);
      run_req("ld_sb0",    0, 2'b00, 0, 32'h0,  32'h0, 3, 32'h00000001, 0, 4'h0, 0, 32'h0);
      run_req("ld_sh2",    0, 2'b01, 0, 32'h2,  32'h0, 3, 32'hFFFF80F1, 0, 4'h0, 0, 32'h0);
      run_req("ld_ub3",    0, 2'b00, 1, 32'h3,  32'h0, 3, 32'h00000080, 0, 4'h0, 0, 32'h0);
      run_req("ld_w4",     0, 2'b10, 0, 32'h4,  32'h0, 3, 32'hC0DE0001, 0, 4'h0, 0, 32'h4);
      run_req("err_ldw6",  0, 2'b10, 0, 32'h6,  32'h0, 1, 0, 1, 4'h0, 0, 32'h0);
      run_req("err_sth5",  1, 2'b01, 0, 32'h5,  32'hFFFF, 1, 0, 1, 4'h0, 0, 32'h0);
      run_req("err_sz3",   1, 2'b11, 0, 32'h0,  32'hFFFFFFFF, 1, 0, 1, 4'h0, 0, 32'h0);

      sel3 = 1'b1;
      run_req("l3_ld_w4",  0, 2'b10, 0, 32'h4,  32'h0, 5, 32'hC0DE0001, 0, 4'h0, 0, 32'h4);
      run_req("l3_ld_sh2", 0, 2'b01, 0, 32'h2,  32'h0, 5, 32'hFFFF80F1, 0, 4'h0, 0, 32'h0);
      run_req("l3_st_word", 1, 2'b10, 0, 32'h8, 32'h01020304, 2, 0, 0, 4'hF, 32'h01020304, 32'h8);

      @(negedge clk);
      req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("abort_in_wait_addr", obs_ma, 32'h4);
      #2 reset_n = 1'b0;
      #1;
      check_eq("abort_mem_address", obs_ma, 32'd0);
      check_eq("abort_rsp_valid", 32'(obs_rv), 32'd0);
      check_eq("abort_rdata", obs_rd, 32'd0);
      check_eq("abort_ready", 32'(obs_rdy), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      rv_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (obs_rv) rv_cnt++;
         if (obs_mwe != 4'd0) rv_cnt++;
      end
      check_eq("abort_no_response", rv_cnt, 0);
      check_eq("abort_ready_after", 32'(obs_rdy), 32'd1);

      sel3 = 1'b0;
      run_req("post_rst_st", 1, 2'b00, 0, 32'h10, 32'h77, 2, 0, 0, 4'h1, 32'h77777777, 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: READ_LATENCY, default 1, number of wait cycles between address presentation and valid mem_read_data (legal 1..4).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  core load/store request present.
REQ-005 Port: req_ready  out  1  unit can accept a request this cycle.
REQ-006 Port: req_write  in  1  1 = store, 0 = load.
REQ-007 Port: req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port: req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 Port: req_addr  in  32  byte address.
REQ-010 Port: req_wdata  in  32  store data, right-justified.
REQ-011 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-012 Port: rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 Port: rsp_error  out  1  misaligned or illegal-size request; valid with rsp_valid.
REQ-014 Port: mem_address  out  32  word address to memory map, {req_addr[31:2],2'b00}.
REQ-015 Port: mem_write_data  out  32  lane-replicated store data.
REQ-016 Port: mem_write_enable  out  4  per-byte write strobes.
REQ-017 Port: mem_read_data  in  32  memory map read data.

Function
REQ-018 FSM states IDLE, ACCESS, WAIT, DONE; all outputs registered or decoded from state registers only.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready; all request fields latched at acceptance.
REQ-020 IDLE -> ACCESS on accept of an aligned legal request; IDLE -> DONE directly on accept of a misaligned or illegal request (no memory access, strobes stay 0).
REQ-021 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; req_size=11 is always illegal.
REQ-022 ACCESS lasts exactly one cycle; mem_address driven from ACCESS through last WAIT cycle and held stable.
REQ-023 Stores: mem_write_enable nonzero only in ACCESS; byte -> 4'b0001<<addr[1:0], data {4{wdata[7:0]}}; half -> addr[1]?4'b1100:4'b0011, data {2{wdata[15:0]}}; word -> 4'b1111, data wdata; ACCESS -> DONE.
REQ-024 Loads: mem_write_enable=0 throughout; ACCESS -> WAIT; WAIT lasts READ_LATENCY cycles via down-counter; mem_read_data captured at end of last WAIT cycle; WAIT -> DONE.
REQ-025 Load extraction: byte = mem_read_data >> (8*addr[1:0]) low 8 bits; half = addr[1] ? [31:16] : [15:0]; word unmodified; extension per req_unsigned.
REQ-026 DONE lasts one cycle with rsp_valid=1, then -> IDLE; response has no backpressure.
REQ-027 Latency accept-to-rsp_valid: store 2 cycles, load 2+READ_LATENCY cycles, error 1 cycle.
REQ-028 rsp_rdata and rsp_error SHALL be 0 whenever rsp_valid=0.
REQ-029 Back-to-back: a new request may be accepted the cycle after DONE; no overlap of transactions.
REQ-030 req_valid deasserted in IDLE leaves unit idle with all memory outputs 0.

Reset
REQ-031 reset_n low asynchronously forces IDLE; req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_address=0, mem_write_data=0, mem_write_enable=0, WAIT counter=0.
REQ-032 Reset asserted mid-transaction aborts it: no strobe, no response after release.

Verification
REQ-033 Store word 0xDEADBEEF to 0x10 -> ACCESS cycle: mem_address=0x10, strobes 1111, data 0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_error=0.
REQ-034 Store byte 0xA5 to 0x13 -> strobes 1000, data 0xA5A5A5A5; store half 0x1234 to 0x22 -> strobes 1100, data 0x12341234.
REQ-035 Memory returns 0x80F17F01: signed byte load @0x3 -> 0xFFFFFF80; unsigned half @0x2 -> 0x000080F1; signed byte @0x0 -> 0x00000001; rsp_valid 3 cycles after accept (READ_LATENCY=1).
REQ-036 Load word @0x6, store half @0x5, req_size=11 @0x0 -> rsp_error=1 one cycle after accept, strobes stay 0000, rsp_rdata=0.
REQ-037 reset_n pulsed low during WAIT -> outputs zero immediately, no rsp_valid, req_ready=1 after release; READ_LATENCY=3 load -> rsp_valid 5 cycles after accept.
